chess_clock_ctrl: RTL and testbench

- Two-player chess clock controller and sole Avalon-MM master of the 16-bit-register interval timer.
- After reset it programs the timer period for a 1-tick base, then starts, pauses and stops the timer in continuous, interrupt-enabled mode.
- On each timer irq it clears the timeout status and charges one tick to the active player.
- Sits between the game-logic FSM (start, move, pause pulses) and the timer's s1 slave; outputs feed the display.

---
 rtl/chess_clock_pkg.sv | 19 +
 rtl/chess_clock_player_time.sv | 39 +++
 rtl/chess_clock_ctrl.sv | 146 ++++++++++++++
 tb/tb_chess_clock_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/chess_clock_pkg.sv
// chess_clock_pkg: timer register map, control words and controller states
package chess_clock_pkg;
  localparam logic [3:0] ADDR_STATUS  = 4'd0;
  localparam logic [3:0] ADDR_CONTROL = 4'd1;
  localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
  localparam logic [3:0] ADDR_PERIOD1 = 4'd3;
  localparam logic [3:0] ADDR_PERIOD2 = 4'd4;
  localparam logic [3:0] ADDR_PERIOD3 = 4'd5;
  localparam int BIT_ITO   = 0;
  localparam int BIT_CONT  = 1;
  localparam int BIT_START = 2;
  localparam int BIT_STOP  = 3;
  localparam logic [15:0] CTRL_RUN   = 16'((1 << BIT_ITO) | (1 << BIT_CONT) | (1 << BIT_START));
  localparam logic [15:0] CTRL_PAUSE = 16'((1 << BIT_ITO) | (1 << BIT_CONT) | (1 << BIT_STOP));
  localparam logic [15:0] CTRL_STOP  = 16'(1 << BIT_STOP);
  typedef enum logic [3:0] {
    PRG0, PRG1, PRG2, PRG3, IDLE, START_WR, RUN, CLR, CLR_WAIT, PAUSE_WR, PAUSED, STOP_WR, OVER
  } state_t;
endpackage

// File: rtl/chess_clock_player_time.sv
// chess_clock_player_time: per-player remaining ticks with saturating decrement and sticky flags
module chess_clock_player_time #(
  parameter int TIME_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              dec,
  input  logic              sel,
  input  logic              set_flag,
  input  logic [TIME_W-1:0] init,
  output logic [TIME_W-1:0] white_time,
  output logic [TIME_W-1:0] black_time,
  output logic              white_flag,
  output logic              black_flag,
  output logic              zero_next
);
  logic [TIME_W-1:0] cur;
  assign cur = sel ? black_time : white_time;
  assign zero_next = cur <= TIME_W'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      white_time <= '0;
      black_time <= '0;
      white_flag <= 1'b0;
      black_flag <= 1'b0;
    end else if (load) begin
      white_time <= init;
      black_time <= init;
      white_flag <= 1'b0;
      black_flag <= 1'b0;
    end else begin
      if (dec && !sel && white_time != '0) white_time <= white_time - 1'b1;
      if (dec && sel && black_time != '0) black_time <= black_time - 1'b1;
      if (set_flag && !sel) white_flag <= 1'b1;
      if (set_flag && sel) black_flag <= 1'b1;
    end
  end
endmodule

// File: rtl/chess_clock_ctrl.sv
// chess_clock_ctrl: two-player chess clock driving an Avalon-MM interval timer
module chess_clock_ctrl
  import chess_clock_pkg::*;
#(
  parameter int TICK_CYCLES = 50000000,
  parameter int TIME_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              game_start,
  input  logic [TIME_W-1:0] time_init,
  input  logic              move_done,
  input  logic              pause,
  output logic [3:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic              tmr_irq,
  output logic [TIME_W-1:0] white_time,
  output logic [TIME_W-1:0] black_time,
  output logic              active_black,
  output logic              paused,
  output logic              white_flag,
  output logic              black_flag,
  output logic              busy
);
  localparam logic [63:0] PERIOD = 64'(TICK_CYCLES - 1);
  state_t st, nxt;
  logic prg, start_go, move_any, pause_any;
  logic bus_wr;
  logic [3:0] bus_addr;
  logic [15:0] bus_data;
  logic dec, flag_set, toggle, take_move, take_pause, zero_next;
  logic pend_move, pend_pause, pend_start;
  assign prg = st inside {PRG0, PRG1, PRG2, PRG3};
  assign start_go = game_start | pend_start;
  assign move_any = move_done | pend_move;
  assign pause_any = pause | pend_pause;
  assign busy = bus_wr | tmr_chipselect;
  always_comb begin
    nxt = st;
    bus_wr = 1'b0;
    bus_addr = ADDR_STATUS;
    bus_data = '0;
    dec = 1'b0;
    flag_set = 1'b0;
    toggle = 1'b0;
    take_move = 1'b0;
    take_pause = 1'b0;
    case (st)
      PRG0, PRG1, PRG2, PRG3: begin
        bus_wr = 1'b1;
        bus_addr = st == PRG0 ? ADDR_PERIOD0 : st == PRG1 ? ADDR_PERIOD1 :
                   st == PRG2 ? ADDR_PERIOD2 : ADDR_PERIOD3;
        bus_data = PERIOD[{st[1:0], 4'b0000} +: 16];
        nxt = st == PRG3 ? IDLE : state_t'(st + 4'd1);
      end
      IDLE, OVER: nxt = st;
      START_WR: begin
        bus_wr = 1'b1;
        bus_addr = ADDR_CONTROL;
        bus_data = CTRL_RUN;
        nxt = RUN;
      end
      RUN: begin
        if (tmr_irq) nxt = CLR;
        else if (move_any) begin
          toggle = 1'b1;
          take_move = 1'b1;
        end else if (pause_any) begin
          take_pause = 1'b1;
          nxt = PAUSE_WR;
        end
      end
      CLR: begin
        bus_wr = 1'b1;
        dec = 1'b1;
        nxt = zero_next ? STOP_WR : CLR_WAIT;
      end
      CLR_WAIT: nxt = RUN;
      PAUSE_WR: begin
        bus_wr = 1'b1;
        bus_addr = ADDR_CONTROL;
        bus_data = CTRL_PAUSE;
        nxt = PAUSED;
      end
      PAUSED: begin
        if (!tmr_irq && move_any) begin
          toggle = 1'b1;
          take_move = 1'b1;
        end else if (!tmr_irq && pause_any) begin
          take_pause = 1'b1;
          nxt = START_WR;
        end
      end
      STOP_WR: begin
        bus_wr = 1'b1;
        bus_addr = ADDR_CONTROL;
        bus_data = CTRL_STOP;
        flag_set = 1'b1;
        nxt = OVER;
      end
      default: nxt = PRG0;
    endcase
    if (!prg && start_go) nxt = START_WR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= PRG0;
      tmr_chipselect <= 1'b0;
      tmr_write_n <= 1'b1;
      tmr_address <= '0;
      tmr_writedata <= '0;
      active_black <= 1'b0;
      paused <= 1'b0;
      pend_move <= 1'b0;
      pend_pause <= 1'b0;
      pend_start <= 1'b0;
    end else begin
      st <= nxt;
      tmr_chipselect <= bus_wr;
      tmr_write_n <= ~bus_wr;
      tmr_address <= bus_addr;
      tmr_writedata <= bus_data;
      active_black <= game_start ? 1'b0 : active_black ^ toggle;
      paused <= game_start ? 1'b0 : take_pause ? (st == RUN) : paused;
      pend_move <= !(game_start || take_move || st == OVER) && move_any;
      pend_pause <= !(game_start || take_pause || st == OVER) && pause_any;
      pend_start <= prg && start_go;
    end
  end
  chess_clock_player_time #(.TIME_W(TIME_W)) u_time (
    .clk(clk),
    .reset(reset),
    .load(game_start),
    .dec(dec),
    .sel(active_black),
    .set_flag(flag_set),
    .init(time_init),
    .white_time(white_time),
    .black_time(black_time),
    .white_flag(white_flag),
    .black_flag(black_flag),
    .zero_next(zero_next)
  );
endmodule

// File: tb/tb_chess_clock_ctrl.sv
// tb_chess_clock_ctrl: directed scenarios for the chess clock timer master
module tb_chess_clock_ctrl;
  localparam int TW = 12;
  logic clk = 1'b0;
  logic reset, game_start, move_done, pause, tmr_irq;
  logic [TW-1:0] time_init;
  logic [3:0] tmr_address;
  logic tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [TW-1:0] white_time, black_time;
  logic active_black, paused, white_flag, black_flag, busy;
  int n_cmp = 0;
  int n_bad = 0;

  chess_clock_ctrl #(.TICK_CYCLES(10), .TIME_W(TW)) dut (
    .clk(clk), .reset(reset), .game_start(game_start), .time_init(time_init),
    .move_done(move_done), .pause(pause), .tmr_address(tmr_address),
    .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq), .white_time(white_time),
    .black_time(black_time), .active_black(active_black), .paused(paused),
    .white_flag(white_flag), .black_flag(black_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic wait_wr(output bit ok, output logic [3:0] a, output logic [15:0] d);
    ok = 1'b0;
    a = 'x;
    d = 'x;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (tmr_chipselect && !tmr_write_n) begin
        ok = 1'b1;
        a = tmr_address;
        d = tmr_writedata;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; game_start = 0; move_done = 0; pause = 0; tmr_irq = 0; time_init = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b0, 1'b1, 4'd0, 16'd0}) begin n_bad++; $display("FAIL reset_bus got cs=%b wn=%b a=%h d=%h exp cs=0 wn=1 a=0 d=0", tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy got %b exp 1", busy); end
    n_cmp++; if ({white_time, black_time, active_black, paused, white_flag, black_flag} !== '0) begin n_bad++; $display("FAIL reset_state got w=%0d b=%0d ab=%b p=%b wf=%b bf=%b exp all 0", white_time, black_time, active_black, paused, white_flag, black_flag); end
  endtask

  task automatic test_program(input string tag);
    logic [3:0] ea;
    logic [15:0] ed;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ea = 4'(2 + k);
      ed = (k == 0) ? 16'h0009 : 16'h0000;
      n_cmp++; if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, busy} !== {1'b1, 1'b0, ea, ed, 1'b1}) begin n_bad++; $display("FAIL %s_prg%0d got cs=%b wn=%b a=%h d=%h busy=%b exp cs=1 wn=0 a=%h d=%h busy=1", tag, k, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, busy, ea, ed); end
    end
    @(negedge clk);
    n_cmp++; if ({tmr_chipselect, tmr_write_n, busy} !== {1'b0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL %s_idle got cs=%b wn=%b busy=%b exp cs=0 wn=1 busy=0", tag, tmr_chipselect, tmr_write_n, busy); end
  endtask

  task automatic test_start;
    bit ok; logic [3:0] a; logic [15:0] d;
    time_init = 12'd3; game_start = 1'b1;
    @(negedge clk); game_start = 1'b0;
    wait_wr(ok, a, d);
    n_cmp++; if ({ok, a, d} !== {1'b1, 4'd1, 16'h0007}) begin n_bad++; $display("FAIL start_ctrl got ok=%b a=%h d=%h exp ok=1 a=1 d=0007", ok, a, d); end
    n_cmp++; if ({white_time, black_time, active_black} !== {12'd3, 12'd3, 1'b0}) begin n_bad++; $display("FAIL start_times got w=%0d b=%0d ab=%b exp 3 3 0", white_time, black_time, active_black); end
  endtask

  task automatic test_tick;
    bit ok; logic [3:0] a; logic [15:0] d;
    tmr_irq = 1'b1;
    wait_wr(ok, a, d);
    tmr_irq = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({ok, a, d} !== {1'b1, 4'd0, 16'h0000}) begin n_bad++; $display("FAIL tick_status got ok=%b a=%h d=%h exp ok=1 a=0 d=0000", ok, a, d); end
    n_cmp++; if ({white_time, black_time} !== {12'd2, 12'd3}) begin n_bad++; $display("FAIL tick_times got w=%0d b=%0d exp 2 3", white_time, black_time); end
  endtask

  task automatic test_move_with_tick;
    bit ok; logic [3:0] a; logic [15:0] d;
    tmr_irq = 1'b1; move_done = 1'b1;
    @(negedge clk); move_done = 1'b0;
    wait_wr(ok, a, d);
    tmr_irq = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({ok, a, d} !== {1'b1, 4'd0, 16'h0000}) begin n_bad++; $display("FAIL mvtick_status got ok=%b a=%h d=%h exp ok=1 a=0 d=0000", ok, a, d); end
    n_cmp++; if ({white_time, black_time, active_black} !== {12'd1, 12'd3, 1'b1}) begin n_bad++; $display("FAIL mvtick_state got w=%0d b=%0d ab=%b exp 1 3 1", white_time, black_time, active_black); end
    tmr_irq = 1'b1;
    wait_wr(ok, a, d);
    tmr_irq = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({ok, white_time, black_time} !== {1'b1, 12'd1, 12'd2}) begin n_bad++; $display("FAIL black_tick got ok=%b w=%0d b=%0d exp 1 1 2", ok, white_time, black_time); end
  endtask

  task automatic test_pause;
    bit ok; logic [3:0] a; logic [15:0] d;
    int writes;
    pause = 1'b1;
    @(negedge clk); pause = 1'b0;
    wait_wr(ok, a, d);
    n_cmp++; if ({ok, a, d, paused} !== {1'b1, 4'd1, 16'h000B, 1'b1}) begin n_bad++; $display("FAIL pause_ctrl got ok=%b a=%h d=%h p=%b exp ok=1 a=1 d=000b p=1", ok, a, d, paused); end
    writes = 0;
    repeat (50) begin
      @(negedge clk);
      if (tmr_chipselect) writes++;
    end
    n_cmp++; if (writes !== 0) begin n_bad++; $display("FAIL paused_quiet got %0d writes exp 0", writes); end
    n_cmp++; if ({paused, busy, white_time, black_time} !== {1'b1, 1'b0, 12'd1, 12'd2}) begin n_bad++; $display("FAIL paused_hold got p=%b busy=%b w=%0d b=%0d exp 1 0 1 2", paused, busy, white_time, black_time); end
    pause = 1'b1;
    @(negedge clk); pause = 1'b0;
    wait_wr(ok, a, d);
    n_cmp++; if ({ok, a, d, paused} !== {1'b1, 4'd1, 16'h0007, 1'b0}) begin n_bad++; $display("FAIL resume_ctrl got ok=%b a=%h d=%h p=%b exp ok=1 a=1 d=0007 p=0", ok, a, d, paused); end
  endtask

  task automatic test_flag;
    bit ok; logic [3:0] a; logic [15:0] d;
    move_done = 1'b1;
    @(negedge clk); move_done = 1'b0;
    @(negedge clk);
    n_cmp++; if (active_black !== 1'b0) begin n_bad++; $display("FAIL move_back got ab=%b exp 0", active_black); end
    tmr_irq = 1'b1;
    wait_wr(ok, a, d);
    tmr_irq = 1'b0;
    n_cmp++; if ({ok, a, d} !== {1'b1, 4'd0, 16'h0000}) begin n_bad++; $display("FAIL flag_status got ok=%b a=%h d=%h exp ok=1 a=0 d=0000", ok, a, d); end
    wait_wr(ok, a, d);
    n_cmp++; if ({ok, a, d} !== {1'b1, 4'd1, 16'h0008}) begin n_bad++; $display("FAIL stop_ctrl got ok=%b a=%h d=%h exp ok=1 a=1 d=0008", ok, a, d); end
    n_cmp++; if ({white_time, black_time, white_flag, black_flag} !== {12'd0, 12'd2, 1'b1, 1'b0}) begin n_bad++; $display("FAIL flag_state got w=%0d b=%0d wf=%b bf=%b exp 0 2 1 0", white_time, black_time, white_flag, black_flag); end
    move_done = 1'b1; pause = 1'b1;
    @(negedge clk); move_done = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({active_black, paused, white_flag, tmr_chipselect} !== {1'b0, 1'b0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL over_ignore got ab=%b p=%b wf=%b cs=%b exp 0 0 1 0", active_black, paused, white_flag, tmr_chipselect); end
  endtask

  task automatic test_restart;
    bit ok; logic [3:0] a; logic [15:0] d;
    time_init = 12'd5; game_start = 1'b1;
    @(negedge clk); game_start = 1'b0;
    wait_wr(ok, a, d);
    n_cmp++; if ({ok, a, d} !== {1'b1, 4'd1, 16'h0007}) begin n_bad++; $display("FAIL restart_ctrl got ok=%b a=%h d=%h exp ok=1 a=1 d=0007", ok, a, d); end
    n_cmp++; if ({white_time, black_time, white_flag, black_flag} !== {12'd5, 12'd5, 1'b0, 1'b0}) begin n_bad++; $display("FAIL restart_state got w=%0d b=%0d wf=%b bf=%b exp 5 5 0 0", white_time, black_time, white_flag, black_flag); end
  endtask

  task automatic test_reset_mid_write;
    game_start = 1'b1;
    @(negedge clk); game_start = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({tmr_chipselect, tmr_write_n, busy} !== {1'b0, 1'b1, 1'b1}) begin n_bad++; $display("FAIL midreset_bus got cs=%b wn=%b busy=%b exp 0 1 1", tmr_chipselect, tmr_write_n, busy); end
    test_program("reprog");
  endtask

  initial begin
    test_reset;
    test_program("prog");
    test_start;
    test_tick;
    test_move_with_tick;
    test_pause;
    test_flag;
    test_restart;
    test_reset_mid_write;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
